// File: rtl/frame_pixel_streamer.sv
// Raster pixel-stream transmitter: walks a stored frame in a single-port RAM
// row-major and emits one NUM_CHANNELS-wide pixel per beat with sof/eol/eof tags.
module frame_pixel_streamer #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int IMG_WIDTH    = 5,
  parameter int IMG_HEIGHT   = 5,
  parameter int ADDR_WIDTH   = 16,
  parameter int ROW_GAP      = 0,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic                               i_abort,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              o_mem_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_mem_rdata,
  output logic                               o_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data_parallel,
  output logic                               o_sof,
  output logic                               o_eol,
  output logic                               o_eof
);

  localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int GAP_W   = (ROW_GAP      > 0) ? $clog2(ROW_GAP + 1)      : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [ADDR_WIDTH-1:0] addr;
  logic [GAP_W-1:0]      gap_cnt;
  logic [FLUSH_W-1:0]    flush_cnt;

  // vld_pipe[1]: RAM data valid this cycle, vld_pipe[2]: beat on the output
  logic [2:1]            vld_pipe;
  logic [2:0]            tag_s1;

  logic rd_en, last_col, last_row, pipe_busy, gap_last, flush_last, start_ok, abort_ok;

  assign rd_en     = (state == S_READ);
  assign last_col  = (col == COL_W'(IMG_WIDTH - 1));
  assign last_row  = (row == ROW_W'(IMG_HEIGHT - 1));
  assign pipe_busy = |vld_pipe;
  assign gap_last  = (gap_cnt == GAP_W'(ROW_GAP - 1));
  assign flush_last = (FLUSH_CYCLES == 0) || (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1));
  assign start_ok  = (state == S_IDLE) && i_start && !i_abort;
  assign abort_ok  = (state != S_IDLE) && i_abort;

  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_mem_rd_en = rd_en;
  assign o_mem_addr  = addr;
  assign o_valid     = vld_pipe[2];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_READ;
      S_READ: begin
        if (last_col) begin
          if (last_row)         state_nxt = S_FLUSH;
          else if (ROW_GAP > 0) state_nxt = S_GAP;
        end
      end
      S_GAP:   if (gap_last) state_nxt = S_READ;
      // flush count only runs once the last beat has left the pipe
      S_FLUSH: if (!pipe_busy && flush_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_ok) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      gap_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
          end
          gap_cnt   <= '0;
          flush_cnt <= '0;
        end
        S_READ: begin
          addr      <= addr + 1'b1;
          gap_cnt   <= '0;
          flush_cnt <= '0;
          if (last_col) begin
            col <= '0;
            if (!last_row) row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        S_FLUSH: flush_cnt <= pipe_busy ? '0 : flush_cnt + 1'b1;
        default: begin
          gap_cnt   <= '0;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  // Beat tags are computed at read issue and ride with the RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe        <= '0;
      tag_s1          <= '0;
      o_data_parallel <= '0;
      o_sof           <= 1'b0;
      o_eol           <= 1'b0;
      o_eof           <= 1'b0;
    end else if (abort_ok) begin
      vld_pipe <= '0;
      tag_s1   <= '0;
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
      o_eof    <= 1'b0;
    end else begin
      vld_pipe[1] <= rd_en;
      vld_pipe[2] <= vld_pipe[1];
      tag_s1      <= {(row == '0) && (col == '0), last_col, last_col && last_row};
      o_sof       <= vld_pipe[1] & tag_s1[2];
      o_eol       <= vld_pipe[1] & tag_s1[1];
      o_eof       <= vld_pipe[1] & tag_s1[0];
      if (vld_pipe[1]) o_data_parallel <= i_mem_rdata;
    end
  end

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
- Transmit side of the raster pixel-stream interface consumed by line_buffer_with_padding.
- Reads a stored multi-channel frame from a synchronous single-port frame RAM and emits it row-major as one NUM_CHANNELS-wide pixel per beat, qualified by o_valid.
- Supports inter-row idle gaps, a trailing flush period so downstream padding logic can drain, start/abort control and a done pulse.
- Sits between the frame memory and the convolution front end.

Parameters:
- NUM_CHANNELS, 2, channels packed per pixel beat.
- DATA_WIDTH, 8, bits per channel sample.
- IMG_WIDTH, 5, pixels per row.
- IMG_HEIGHT, 5, rows per frame.
- ADDR_WIDTH, 16, frame RAM address width; must satisfy IMG_WIDTH*IMG_HEIGHT <= 2^ADDR_WIDTH.
- ROW_GAP, 0, idle cycles inserted between consecutive rows (0 = back-to-back).
- FLUSH_CYCLES, 8, idle cycles after the last beat before o_done.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  single-cycle frame start request.
- i_abort  in  1  synchronous abort of the current frame.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at frame completion.
- o_mem_rd_en  out  1  frame RAM read enable.
- o_mem_addr  out  ADDR_WIDTH  frame RAM address, row*IMG_WIDTH+col.
- i_mem_rdata  in  NUM_CHANNELS*DATA_WIDTH  RAM read data, valid the cycle after o_mem_rd_en.
- o_valid  out  1  pixel beat valid.
- o_data_parallel  out  NUM_CHANNELS*DATA_WIDTH  pixel beat; channel ch occupies bits [ch*DATA_WIDTH +: DATA_WIDTH].
- o_sof  out  1  qualifies first beat of frame (row 0, col 0).
- o_eol  out  1  qualifies last beat of each row.
- o_eof  out  1  qualifies last beat of frame.

Behaviour:
- Reset (async assert): all outputs 0, including o_data_parallel; FSM = IDLE; row/col/gap/flush counters 0; read pipeline valid bits cleared.
- FSM states: IDLE, READ, GAP, FLUSH, DONE.
- IDLE: i_start=1 -> READ next cycle with row=col=0. o_busy rises the cycle after i_start is sampled.
- READ: o_mem_rd_en=1 and o_mem_addr=row*IMG_WIDTH+col every cycle; col increments.
  - At col=IMG_WIDTH-1, col wraps to 0.
  - If row<IMG_HEIGHT-1: row increments, then -> GAP if ROW_GAP>0, else stay in READ.
  - If row=IMG_HEIGHT-1: -> FLUSH.
- GAP: o_mem_rd_en=0 for exactly ROW_GAP cycles, then -> READ.
- FLUSH: o_mem_rd_en=0. Counts FLUSH_CYCLES cycles starting the cycle after the last o_valid beat (never overlaps in-flight beats), then -> DONE.
- DONE: o_done=1 for one cycle; o_busy is still 1 in this cycle. -> IDLE; o_busy falls next cycle.
- Read latency is fixed: o_mem_rd_en high in cycle n -> i_mem_rdata valid in cycle n+1 -> o_valid/o_data_parallel registered out in cycle n+2.
- o_sof, o_eol and o_eof are pipelined alongside and aligned to the same beat.
- o_data_parallel holds its last value when o_valid=0; downstream must qualify with o_valid.
- Beat count per frame is exactly IMG_WIDTH*IMG_HEIGHT. Back-to-back when ROW_GAP=0; exactly ROW_GAP idle cycles between rows otherwise.
- Address computation uses a running address register incremented by 1 per read (no multiplier). It resets to 0 on frame start.
- i_start while o_busy=1: ignored, no effect on the current frame.
- i_start in the same cycle as o_done: ignored; a new start is accepted only in IDLE.
- i_abort (any non-IDLE state):
  - Next cycle: FSM = IDLE, o_mem_rd_en=0, pipeline valid bits cleared, so no further o_valid beats and no o_done.
  - o_busy falls the cycle after abort is sampled.
  - i_abort in IDLE has no effect.
  - i_abort together with i_start in IDLE: abort wins, no frame starts.
- Reset mid-frame: immediate return to reset state; partial frame is discarded and no o_done is issued.
- Degenerate case IMG_WIDTH=1: o_eol is asserted on every beat.

Test Plan:
- Frame RAM preloaded so ch0=row*10+col and ch1=0xFF, ROW_GAP=0, FLUSH_CYCLES=8, i_start pulse -> 25 consecutive o_valid beats with ch0 = 0,1,...,4,10,...,44; o_sof on the beat with value 0; o_eol on 4,14,24,34,44; o_eof on 44; o_done exactly 9 cycles after the 44 beat (8 flush cycles plus the DONE cycle).
- ROW_GAP=2 -> exactly 2 idle o_valid=0 cycles between beats 4/10, 14/20, 24/30 and 34/40; total beats 25; o_mem_addr sequence 0..24 with no skips.
- Latency check -> first o_valid occurs exactly 2 cycles after the first o_mem_rd_en; o_mem_addr=0 in that rd_en cycle.
- i_start re-pulsed at beat 7 -> ignored; beat sequence unchanged; one o_done only.
- i_abort asserted while beat 12 (ch0=22) is on the output -> no beats after the abort takes effect; o_done never pulses; o_busy=0 one cycle later; next i_start restarts at address 0 with o_sof on value 0.
- rst asserted asynchronously mid-row -> o_valid, o_busy and o_mem_rd_en drop to 0 immediately; after release, a new i_start yields a clean full 25-beat frame.
